// File: rtl/rx_char_restore_if.sv
// Lane-side bundle for the JESD204B character-restore stage: decoded octets
// with their control flags on the way in, restored octets, valid and
// per-octet frame/multiframe/error markers on the way out.
interface rx_char_restore_if;
    logic            en;
    logic [7:0]      f;
    logic [4:0]      k;
    logic [3:0][7:0] dec_data;
    logic [3:0]      dec_k;
    logic [3:0][7:0] res_data;
    logic            vld;
    logic [3:0]      fe;
    logic [3:0]      me;
    logic [3:0]      align_err;
    logic [3:0]      unexp_k;

    modport master (
        output en, f, k, dec_data, dec_k,
        input  res_data, vld, fe, me, align_err, unexp_k
    );

    modport slave (
        input  en, f, k, dec_data, dec_k,
        output res_data, vld, fe, me, align_err, unexp_k
    );
endinterface

// File: rtl/rx_char_restore.sv
// JESD204B lane receiver stage after the 8b10b decoder (no scrambling),
// four octets per clock. Tracks frame/multiframe position from the start of
// user data, restores /F/ and /A/ at frame ends to the previous frame-end
// octet, and flags misplaced alignment and unexpected control characters.
// Two-cycle latency: stage 1 registers octets and position, stage 2 restores.
module rx_char_restore #(
    parameter int RESTORE   = 1,
    parameter int CHK_UNEXP = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    rx_char_restore_if.slave  bus
);
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] CHAR_F = 8'hFC;
    localparam logic [DATA_W-1:0] CHAR_A = 8'h7C;

    logic [3:0]              fe_pos;
    logic [7:0]              mf_oct;
    logic [5:0]              wrap_at;
    logic [5:0]              wcnt;
    logic                    me_now;

    logic [3:0][DATA_W-1:0]  di_p1;
    logic [3:0]              ki_p1;
    logic [3:0]              fe_p1;
    logic                    me_p1;
    logic                    vld_p1;

    logic [3:0]              is_f;
    logic [3:0]              is_a;
    logic [3:0][DATA_W-1:0]  restored;
    logic [3:0]              aerr_c;
    logic [3:0]              unexp_c;
    logic [DATA_W-1:0]       prev;

    logic [3:0][DATA_W-1:0]  res_p2;
    logic                    vld_p2;
    logic [3:0]              fe_p2;
    logic [3:0]              me_p2;
    logic [3:0]              aerr_p2;
    logic [3:0]              unexp_p2;
    logic [DATA_W-1:0]       last;

    // Frame-end octet mask and last word index of the multiframe from F/K.
    always_comb begin
        fe_pos = 4'b1000;
        mf_oct = 8'({3'b000, bus.k}) + 8'd1;
        if (bus.f == 8'd0) begin
            fe_pos = 4'b1111;
        end else if (bus.f == 8'd1) begin
            fe_pos = 4'b1010;
            mf_oct = mf_oct << 1;
        end else begin
            mf_oct = mf_oct << 2;
        end
        wrap_at = 6'(mf_oct >> 2) - 6'd1;
        me_now  = fe_pos[3] && (wcnt == wrap_at);
    end

    // Word position inside the multiframe; held at 0 while user data is off.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wcnt <= 6'd0;
        end else if (!bus.en) begin
            wcnt <= 6'd0;
        end else if (wcnt == wrap_at) begin
            wcnt <= 6'd0;
        end else begin
            wcnt <= wcnt + 6'd1;
        end
    end

    // Stage 1: capture octets, control flags and position markers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            di_p1  <= '0;
            ki_p1  <= '0;
            fe_p1  <= '0;
            me_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            di_p1  <= bus.dec_data;
            ki_p1  <= bus.dec_k;
            fe_p1  <= bus.en ? fe_pos : 4'b0000;
            me_p1  <= bus.en && me_now;
            vld_p1 <= bus.en;
        end
    end

    // Classify each captured octet as /F/, /A/ or neither.
    always_comb begin
        is_f = '0;
        is_a = '0;
        for (int i = 0; i < 4; i++) begin
            is_f[i] = ki_p1[i] && (di_p1[i] == CHAR_F);
            is_a[i] = ki_p1[i] && (di_p1[i] == CHAR_A);
        end
    end

    // Restore chain from octet 0 to 3; each frame end feeds the next one.
    always_comb begin
        restored = di_p1;
        aerr_c   = '0;
        unexp_c  = '0;
        prev     = last;
        for (int i = 0; i < 4; i++) begin
            if (fe_p1[i]) begin
                if (is_f[i] || is_a[i]) begin
                    if (RESTORE != 0) begin
                        restored[i] = prev;
                    end
                    if (is_a[i] && !((i == 3) && me_p1)) begin
                        aerr_c[i] = 1'b1;
                    end
                end
                prev = restored[i];
            end else if (is_f[i] || is_a[i]) begin
                aerr_c[i] = 1'b1;
            end
            if (ki_p1[i] && !is_f[i] && !is_a[i] && (CHK_UNEXP != 0)) begin
                unexp_c[i] = 1'b1;
            end
        end
    end

    // Stage 2: register restored word and flags; an idle word clears LAST.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            res_p2   <= '0;
            vld_p2   <= 1'b0;
            fe_p2    <= '0;
            me_p2    <= '0;
            aerr_p2  <= '0;
            unexp_p2 <= '0;
            last     <= '0;
        end else begin
            res_p2   <= vld_p1 ? restored : '0;
            vld_p2   <= vld_p1;
            fe_p2    <= vld_p1 ? fe_p1 : 4'b0000;
            me_p2    <= {vld_p1 && me_p1, 3'b000};
            aerr_p2  <= vld_p1 ? aerr_c : 4'b0000;
            unexp_p2 <= vld_p1 ? unexp_c : 4'b0000;
            last     <= vld_p1 ? restored[3] : '0;
        end
    end

    assign bus.res_data  = res_p2;
    assign bus.vld       = vld_p2;
    assign bus.fe        = fe_p2;
    assign bus.me        = me_p2;
    assign bus.align_err = aerr_p2;
    assign bus.unexp_k   = unexp_p2;
endmodule

// File: tb/tb_rx_char_restore.sv
// Scoreboard bench for rx_char_restore: every driven word pushes its
// expected output; sampled outputs are paired two words later.
module tb_rx_char_restore;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rx_char_restore_if bus();

    rx_char_restore #(.RESTORE(1), .CHK_UNEXP(1)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        vld;
        logic [3:0]  fe;
        logic [3:0]  me;
        logic [3:0]  aerr;
        logic [3:0]  unexp;
    } out_t;

    out_t exp_q[$];
    out_t obs_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic out_t mk(input logic [31:0] d, input logic v, input logic [3:0] fe,
                                input logic [3:0] me, input logic [3:0] ae, input logic [3:0] uk);
        out_t o;
        o = {d, v, fe, me, ae, uk};
        return o;
    endfunction

    function automatic logic [31:0] pw(input int base);
        return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
    endfunction

    // One clock: sample outputs, drive one word, record its expectation.
    task automatic cycle(input logic en, input logic [31:0] di, input logic [3:0] ki, input out_t e);
        out_t o;
        @(negedge clk);
        o = {bus.res_data, bus.vld, bus.fe, bus.me, bus.align_err, bus.unexp_k};
        obs_q.push_back(o);
        bus.en       = en;
        bus.dec_data = di;
        bus.dec_k    = ki;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'h0, mk(32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
    endtask

    // Start a scenario with fresh queues and new framing.
    task automatic start(input logic [7:0] f, input logic [4:0] k);
        idle(2);
        bus.f = f;
        bus.k = k;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Flush the pipe and line up observations with the words that produced them.
    task automatic finish_words();
        idle(2);
        void'(obs_q.pop_front());
        void'(obs_q.pop_front());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.f        = 8'd0;
        bus.k        = 5'd0;
        bus.dec_data = 32'h0;
        bus.dec_k    = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.res_data !== 32'h0 || bus.vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%b required=00000000/0", bus.res_data, bus.vld);
        end
        checks++;
        if ({bus.fe, bus.me, bus.align_err, bus.unexp_k} !== 16'h0) begin
            failures++;
            $display("FAIL reset_flags actual=%h required=0000", {bus.fe, bus.me, bus.align_err, bus.unexp_k});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_f1_frames();
        out_t e, o;
        start(8'd0, 5'd3);
        cycle(1'b1, 32'h44332211, 4'b0000, mk(32'h44332211, 1'b1, 4'hF, 4'h8, 4'h0, 4'h0));
        cycle(1'b1, 32'h7CFC55FC, 4'b1101, mk(32'h55555544, 1'b1, 4'hF, 4'h8, 4'h0, 4'h0));
        finish_words();
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (e.vld ? (o !== e) : (o.vld !== 1'b0)) begin
                failures++;
                $display("FAIL f1_frames word%0d actual=%h required=%h", i, o, e);
            end
        end
    endtask

    task automatic test_f2_chain();
        out_t e, o;
        start(8'd1, 5'd1);
        cycle(1'b1, 32'hD3C2B1A0, 4'b0000, mk(32'hD3C2B1A0, 1'b1, 4'hA, 4'h8, 4'h0, 4'h0));
        cycle(1'b1, 32'hFC10FC20, 4'b1010, mk(32'hD310D320, 1'b1, 4'hA, 4'h8, 4'h0, 4'h0));
        finish_words();
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (e.vld ? (o !== e) : (o.vld !== 1'b0)) begin
                failures++;
                $display("FAIL f2_chain word%0d actual=%h required=%h", i, o, e);
            end
        end
    endtask

    task automatic test_align();
        out_t e, o;
        logic [31:0] d, x;
        logic [3:0]  ki;
        logic [7:0]  last;
        start(8'd3, 5'd7);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d  = pw(8'h20 + 4 * i);
            x  = d;
            ki = 4'b0000;
            if (i == 3 || i == 7) begin
                d[31:24] = 8'h7C;
                ki       = 4'b1000;
                x[31:24] = last;
            end
            cycle(1'b1, d, ki, mk(x, 1'b1, 4'h8, (i % 8 == 7) ? 4'h8 : 4'h0,
                                  (i == 3) ? 4'h8 : 4'h0, 4'h0));
            last = x[31:24];
        end
        finish_words();
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (e.vld ? (o !== e) : (o.vld !== 1'b0)) begin
                failures++;
                $display("FAIL align word%0d actual=%h required=%h", i, o, e);
            end
        end
    endtask

    task automatic test_misplaced();
        out_t e, o;
        start(8'd3, 5'd7);
        cycle(1'b1, 32'h13121110, 4'b0000, mk(32'h13121110, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0));
        cycle(1'b1, 32'h2322FC20, 4'b0010, mk(32'h2322FC20, 1'b1, 4'h8, 4'h0, 4'h2, 4'h0));
        cycle(1'b1, 32'h33BC3130, 4'b0100, mk(32'h33BC3130, 1'b1, 4'h8, 4'h0, 4'h0, 4'h4));
        cycle(1'b1, 32'hFC424140, 4'b1000, mk(32'h33424140, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0));
        finish_words();
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (e.vld ? (o !== e) : (o.vld !== 1'b0)) begin
                failures++;
                $display("FAIL misplaced word%0d actual=%h required=%h", i, o, e);
            end
        end
    endtask

    task automatic test_en_drop();
        out_t e, o;
        logic [31:0] d;
        start(8'd3, 5'd7);
        for (int i = 0; i < 5; i++) begin
            d = pw(8'h60 + 4 * i);
            cycle(1'b1, d, 4'b0000, mk(d, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0));
        end
        cycle(1'b0, 32'hA5A5A5A5, 4'b0000, mk(32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int i = 0; i < 9; i++) begin
            d = pw(8'h80 + 4 * i);
            if (i == 0) begin
                cycle(1'b1, {8'hFC, d[23:0]}, 4'b1000,
                      mk({8'h00, d[23:0]}, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0));
            end else begin
                cycle(1'b1, d, 4'b0000, mk(d, 1'b1, 4'h8, (i == 7) ? 4'h8 : 4'h0, 4'h0, 4'h0));
            end
        end
        finish_words();
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (e.vld ? (o !== e) : (o.vld !== 1'b0)) begin
                failures++;
                $display("FAIL en_drop word%0d actual=%h required=%h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        start(8'd3, 5'd7);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, pw(8'h90 + 4 * i), 4'b0000, mk(32'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.res_data !== 32'h0 || bus.vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_data actual=%h/%b required=00000000/0", bus.res_data, bus.vld);
        end
        checks++;
        if ({bus.fe, bus.me, bus.align_err, bus.unexp_k} !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_flags actual=%h required=0000", {bus.fe, bus.me, bus.align_err, bus.unexp_k});
        end
        w0 = pw(8'hB0);
        @(negedge clk);
        bus.dec_data = w0;
        bus.dec_k    = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.dec_data = pw(8'hC0);
        checks++;
        if (bus.vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_vld1 actual=%b required=0", bus.vld);
        end
        @(negedge clk);
        checks++;
        if (bus.vld !== 1'b1 || bus.res_data !== w0) begin
            failures++;
            $display("FAIL reset_release_vld2 actual=%b/%h required=1/%h", bus.vld, bus.res_data, w0);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_f1_frames();
        test_f2_chain();
        test_align();
        test_misplaced();
        test_en_drop();
        test_reset_mid();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
